// File: rtl/cordic_rotate_pkg.sv
// Shared constants for the rotation/vectoring CORDIC pair: angle constants in
// Q4.16, the CORDIC gain seed in Q2.22, the arctangent table and the FSM states.
package cordic_rotate_pkg;

  localparam int Z_W  = 20;   // Q4.16 angle accumulator
  localparam int XY_W = 24;   // Q2.22 x/y datapath

  localparam logic [Z_W-1:0]  PI        = 20'h3243F;
  localparam logic [Z_W-1:0]  PI_2      = 20'h19220;
  localparam logic [Z_W-1:0]  PI3_2     = 20'h4B65F;
  localparam logic [Z_W-1:0]  TWO_PI    = 20'h6487F;
  localparam logic [XY_W-1:0] K_INIT    = 24'h26DD3B;
  localparam logic [15:0]     ANGLE_MAX = 16'h0648;

  // atan(2^-i) in Q4.16, i = 0..15
  localparam logic [Z_W-1:0] ATAN_TABLE [16] = '{
    20'h0C910, 20'h076B2, 20'h03EB7, 20'h01FD6,
    20'h00FFB, 20'h007FF, 20'h00400, 20'h00200,
    20'h00100, 20'h00080, 20'h00040, 20'h00020,
    20'h00010, 20'h00008, 20'h00004, 20'h00002
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_OUT
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, shared by the rotation and vectoring CORDICs.
module cordic_atan_rom
  import cordic_rotate_pkg::*;
(
  input  logic [3:0]     idx,
  output logic [Z_W-1:0] atan_val
);

  assign atan_val = ATAN_TABLE[idx];

endmodule

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: Q8.8 angle in, Q1.14 cosine/sine out,
// one micro-rotation per clock under a start/busy/done handshake.
module cordic_rotate
  import cordic_rotate_pkg::*;
#(
  parameter int ITER  = 16,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      angle_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [OUT_W-1:0] cos_out,
  output logic [OUT_W-1:0] sin_out
);

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_t                 state_reg, state_next;
  logic [15:0]            angle_reg, angle_next;
  logic signed [XY_W-1:0] x_reg, x_next;
  logic signed [XY_W-1:0] y_reg, y_next;
  logic signed [Z_W-1:0]  z_reg, z_next;
  logic                   neg_reg, neg_next;
  logic [3:0]             iter_reg, iter_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   err_reg, err_next;
  logic [OUT_W-1:0]       cos_reg, cos_next;
  logic [OUT_W-1:0]       sin_reg, sin_next;

  logic signed [XY_W-1:0] x_sh, y_sh;
  logic [Z_W-1:0]         z_raw;
  logic [Z_W-1:0]         atan_val;
  logic                   bad_angle;
  logic [OUT_W-1:0]       x_trunc, y_trunc;

  cordic_atan_rom u_atan_rom (
    .idx      (iter_reg),
    .atan_val (atan_val)
  );

  assign x_sh      = x_reg >>> iter_reg;
  assign y_sh      = y_reg >>> iter_reg;
  // Legal angles fit in 12 integer+fraction bits, so Q8.8 widens to Q4.16 losslessly.
  assign z_raw     = {angle_reg[11:0], 8'h00};
  assign bad_angle = (angle_reg > ANGLE_MAX);
  assign x_trunc   = x_reg[XY_W-1 -: OUT_W];
  assign y_trunc   = y_reg[XY_W-1 -: OUT_W];

  always_comb begin
    state_next = state_reg;
    angle_next = angle_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    neg_next   = neg_reg;
    iter_next  = iter_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    cos_next   = cos_reg;
    sin_next   = sin_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          angle_next = angle_in;
          busy_next  = 1'b1;
          state_next = ST_PREP;
        end
      end

      ST_PREP: begin
        x_next    = $signed(K_INIT);
        y_next    = '0;
        iter_next = '0;
        neg_next  = 1'b0;
        z_next    = $signed(z_raw);
        if (bad_angle) begin
          state_next = ST_OUT;
        end else begin
          state_next = ST_ITER;
          // Fold into [-pi/2, pi/2]; the middle half-turn is rotated by pi and negated at the end.
          if (z_raw <= PI_2) begin
            z_next = $signed(z_raw);
          end else if (z_raw <= PI3_2) begin
            z_next   = $signed(z_raw - PI);
            neg_next = 1'b1;
          end else begin
            z_next = $signed(z_raw - TWO_PI);
          end
        end
      end

      ST_ITER: begin
        if (!z_reg[Z_W-1]) begin
          x_next = x_reg - y_sh;
          y_next = y_reg + x_sh;
          z_next = z_reg - $signed(atan_val);
        end else begin
          x_next = x_reg + y_sh;
          y_next = y_reg - x_sh;
          z_next = z_reg + $signed(atan_val);
        end
        if (iter_reg == LAST_ITER) begin
          state_next = ST_OUT;
        end else begin
          iter_next = iter_reg + 4'd1;
        end
      end

      ST_OUT: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        err_next   = bad_angle;
        state_next = ST_IDLE;
        if (bad_angle) begin
          cos_next = '0;
          sin_next = '0;
        end else if (neg_reg) begin
          cos_next = -x_trunc;
          sin_next = -y_trunc;
        end else begin
          cos_next = x_trunc;
          sin_next = y_trunc;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      angle_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      neg_reg   <= 1'b0;
      iter_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cos_reg   <= '0;
      sin_reg   <= '0;
    end else begin
      state_reg <= state_next;
      angle_reg <= angle_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      z_reg     <= z_next;
      neg_reg   <= neg_next;
      iter_reg  <= iter_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      cos_reg   <= cos_next;
      sin_reg   <= sin_next;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign cos_out = cos_reg;
  assign sin_out = sin_reg;

endmodule

// File: tb/tb_cordic_rotate.sv
// Scoreboard bench for cordic_rotate: expected cos/sin come from real-valued
// trigonometry on the input angle; a monitor pops and compares on every done.
module tb_cordic_rotate;

  localparam int ITER  = 16;
  localparam int OUT_W = 16;
  localparam int TOL   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      angle_in = '0;
  logic             busy, done, err;
  logic [OUT_W-1:0] cos_out, sin_out;

  cordic_rotate #(.ITER(ITER), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .angle_in (angle_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cos_out  (cos_out),
    .sin_out  (sin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] angle;
    bit          err;
    int          cosv;
    int          sinv;
    int          scyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int to_q14(real v);
    real s;
    s = v * 16384.0;
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  // Reference: exact trig of the Q8.8 angle; out-of-range angles give err and zeros.
  function automatic exp_t model(input logic [15:0] a, input int scyc);
    exp_t e;
    real  rad;
    e.angle = a;
    e.scyc  = scyc;
    if (a > 16'h0648) begin
      e.err  = 1'b1;
      e.cosv = 0;
      e.sinv = 0;
    end else begin
      rad    = real'(a) / 256.0;
      e.err  = 1'b0;
      e.cosv = to_q14($cos(rad));
      e.sinv = to_q14($sin(rad));
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req, input int tol);
    int diff;
    checks++;
    diff = act - req;
    if (diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding request.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no request outstanding at cycle %0d", cyc);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - e.scyc;
          check("latency", lat, e.err ? 2 : ITER + 2, 0);
          check("err", int'(err), int'(e.err), 0);
          check("cos_out", int'($signed(cos_out)), e.cosv, e.err ? 0 : TOL);
          check("sin_out", int'($signed(sin_out)), e.sinv, e.err ? 0 : TOL);
          check("busy_at_done", int'(busy), 0, 0);
          $display("txn angle=%h cos=%h sin=%h err=%b latency=%0d", e.angle, cos_out, sin_out, err, lat);
        end
      end
    end
  end

  // Drive one start; optionally release reset on the same cycle to prove the
  // first post-reset edge is honoured. Latency is counted from the sampling edge.
  task automatic issue(input logic [15:0] a, input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    start    = 1'b1;
    angle_in = a;
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, cyc));
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", int'(busy), 1, 0);
    check("done_after_start", int'(done), 0, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results still outstanding after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  localparam int N_DIR = 12;
  logic [15:0] dir_angles [N_DIR] = '{
    16'h0000, 16'h00C9, 16'h0192, 16'h0324, 16'h04B6, 16'h0648,
    16'h0700, 16'h0010, 16'h0191, 16'h0193, 16'h04B7, 16'h0649
  };

  initial begin
    logic [15:0] a;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_err", int'(err), 0, 0);
    check("rst_cos", int'(cos_out), 0, 0);
    check("rst_sin", int'(sin_out), 0, 0);

    issue(dir_angles[0], 1'b1);
    wait_idle();
    for (int i = 1; i < N_DIR; i++) begin
      issue(dir_angles[i], 1'b0);
      wait_idle();
    end

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) a = 16'($urandom_range(16'h0649, 16'hFFFF));
      else                           a = 16'($urandom_range(0, 16'h0648));
      issue(a, 1'b0);
      wait_idle();
    end

    // A second start while busy must not produce a second result.
    issue(16'h0100, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    angle_in = 16'h0500;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);

    // Abort mid-iteration: outputs clear without a clock, no done afterwards.
    issue(16'h0200, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    angle_in = 16'h0300;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    check("abort_err", int'(err), 0, 0);
    check("abort_cos", int'(cos_out), 0, 0);
    check("abort_sin", int'(sin_out), 0, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("idle_after_abort", int'(busy), 0, 0);

    issue(16'h0100, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
